// File: rtl/dll_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dll_pkg
//  Purpose  : Shared types and constants for the DLL transmit arbiter: link
//             state encoding, arbiter FSM states, beat/DLLP widths, one-hot
//             select bit positions and the DLLP-to-beat packing helper.
//  Revision : 1.0  initial release
// ============================================================================
package dll_pkg;

    localparam int DLLP_WIDTH      = 64;
    localparam int PIPE_DATA_WIDTH = 256;

    // Link state as presented by the DLCMSM; encoding 3 is treated as inactive.
    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_INIT     = 2'd1,
        DL_ACTIVE   = 2'd2
    } dlcm_state_t;

    // IDLE is a packet boundary; TLP_BUSY means a TLP has started and must finish.
    typedef enum logic {
        TXA_IDLE     = 1'b0,
        TXA_TLP_BUSY = 1'b1
    } txa_state_t;

    // Bit positions inside the one-hot select vector.
    localparam int SEL_ACK = 0;
    localparam int SEL_FC  = 1;
    localparam int SEL_TLP = 2;
    localparam int SEL_W   = 3;

    // A DLLP occupies the low bits of the beat; the rest of the beat is zero.
    function automatic logic [PIPE_DATA_WIDTH-1:0] dllp_beat(input logic [DLLP_WIDTH-1:0] dllp);
        return {{(PIPE_DATA_WIDTH-DLLP_WIDTH){1'b0}}, dllp};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dll_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dll_tx_arbiter_if
//  Purpose  : Bundles the requester, TLP-stream and PIPE-side signals of the
//             DLL transmit arbiter.
//             slave  : arbiter view (requests/data in, grants/beat out)
//             master : requester/PIPE view (opposite directions)
//  Signals  : dlcm_state_i, pipe_ready_i, ack_req_i/ack_dllp_i/ack_gnt_o,
//             fc_req_i/fc_dllp_i/fc_gnt_o, tlp_valid_i/sop/eop/data/ready_o,
//             dll2pipe_data_o/valid_o/dllp_o
//  Revision : 1.0  initial release
// ============================================================================
interface dll_tx_arbiter_if;
    import dll_pkg::*;

    logic [1:0]                 dlcm_state_i;
    logic                       pipe_ready_i;
    logic                       ack_req_i;
    logic [DLLP_WIDTH-1:0]      ack_dllp_i;
    logic                       ack_gnt_o;
    logic                       fc_req_i;
    logic [DLLP_WIDTH-1:0]      fc_dllp_i;
    logic                       fc_gnt_o;
    logic                       tlp_valid_i;
    logic                       tlp_sop_i;
    logic                       tlp_eop_i;
    logic [PIPE_DATA_WIDTH-1:0] tlp_data_i;
    logic                       tlp_ready_o;
    logic [PIPE_DATA_WIDTH-1:0] dll2pipe_data_o;
    logic                       dll2pipe_valid_o;
    logic                       dll2pipe_dllp_o;

    modport slave (
        input  dlcm_state_i, pipe_ready_i,
        input  ack_req_i, ack_dllp_i, fc_req_i, fc_dllp_i,
        input  tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i,
        output ack_gnt_o, fc_gnt_o, tlp_ready_o,
        output dll2pipe_data_o, dll2pipe_valid_o, dll2pipe_dllp_o
    );

    modport master (
        output dlcm_state_i, pipe_ready_i,
        output ack_req_i, ack_dllp_i, fc_req_i, fc_dllp_i,
        output tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i,
        input  ack_gnt_o, fc_gnt_o, tlp_ready_o,
        input  dll2pipe_data_o, dll2pipe_valid_o, dll2pipe_dllp_o
    );

endinterface
`default_nettype wire

// File: rtl/dll_tx_arbiter_sel.sv
`default_nettype none
// ============================================================================
//  Module   : dll_tx_arb_sel
//  Purpose  : Combinational eligibility/priority picker for the DLL transmit
//             arbiter. Produces a one-hot (or zero) select over
//             {TLP, FC, ACK}; the caller qualifies it with PIPE readiness.
//  Ports    : busy       in  arbiter is inside a TLP
//             dlcm_state in  link state (0 inactive, 1 init, 2 active, 3 inactive)
//             ack_req    in  ACK/NAK DLLP pending
//             fc_req     in  FC DLLP pending
//             tlp_valid  in  TLP beat valid
//             tlp_sop    in  TLP beat is a start of packet
//             burst_full in  DLLP burst limit reached while a TLP waits
//             sel        out one-hot select, bit positions SEL_ACK/FC/TLP
//  Revision : 1.0  initial release
// ============================================================================
module dll_tx_arb_sel
    import dll_pkg::*;
(
    input  logic             busy,
    input  logic [1:0]       dlcm_state,
    input  logic             ack_req,
    input  logic             fc_req,
    input  logic             tlp_valid,
    input  logic             tlp_sop,
    input  logic             burst_full,
    output logic [SEL_W-1:0] sel
);

    logic w_tlp_sop_wait;

    assign w_tlp_sop_wait = tlp_valid & tlp_sop;

    always_comb begin
        sel = '0;
        if (busy) begin
            // Mid-TLP only the stream may continue; sop here is just data.
            sel[SEL_TLP] = tlp_valid;
        end else if (dlcm_state == DL_INIT) begin
            sel[SEL_FC] = fc_req;
        end else if (dlcm_state == DL_ACTIVE) begin
            if (burst_full && w_tlp_sop_wait) begin
                // Starvation override: the waiting TLP jumps the DLLPs.
                sel[SEL_TLP] = 1'b1;
            end else if (ack_req) begin
                sel[SEL_ACK] = 1'b1;
            end else if (fc_req) begin
                sel[SEL_FC] = 1'b1;
            end else if (w_tlp_sop_wait) begin
                sel[SEL_TLP] = 1'b1;
            end
        end
        // Inactive (0 or 3): nothing is eligible.
    end

endmodule
`default_nettype wire

// File: rtl/dll_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dll_tx_arbiter
//  Purpose  : Owns the DLL->PIPE transmit beat. Arbitrates ACK/NAK DLLPs,
//             FC DLLPs and the TLP stream by link state, never splits a TLP,
//             bounds TLP starvation by MAX_DLLP_BURST and registers the
//             chosen beat toward the PIPE (latency 1).
//  Ports    : sclk   in  clock
//             srst_n in  asynchronous active-low reset
//             bus    slave modport of dll_tx_arbiter_if (requests, TLP
//                    stream, grants, registered PIPE beat)
//  Revision : 1.0  initial release
// ============================================================================
module dll_tx_arbiter
    import dll_pkg::*;
#(
    parameter int MAX_DLLP_BURST = 4
)
(
    input  logic              sclk,
    input  logic              srst_n,
    dll_tx_arbiter_if.slave   bus
);

    localparam int               CNT_W   = $clog2(MAX_DLLP_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DLLP_BURST);

    txa_state_t                 r_state;
    txa_state_t                 w_next_state;
    logic [CNT_W-1:0]           r_dllp_cnt;
    logic [CNT_W-1:0]           w_dllp_cnt_nxt;

    logic [SEL_W-1:0]           w_sel;
    logic                       w_busy;
    logic                       w_active;
    logic                       w_advance;
    logic                       w_ack_gnt;
    logic                       w_fc_gnt;
    logic                       w_tlp_ready;
    logic                       w_tlp_take;
    logic                       w_sop_wait;
    logic [PIPE_DATA_WIDTH-1:0] w_beat;

    logic [PIPE_DATA_WIDTH-1:0] r_data;
    logic                       r_valid;
    logic                       r_dllp;

    assign w_busy     = (r_state == TXA_TLP_BUSY);
    assign w_active   = (bus.dlcm_state_i == DL_ACTIVE);
    assign w_sop_wait = bus.tlp_valid_i & bus.tlp_sop_i;

    // Reset is folded in so grants/ready read as zero while reset is held,
    // even though requests may still be asserted.
    assign w_advance  = bus.pipe_ready_i & srst_n;

    dll_tx_arb_sel u_sel (
        .busy       (w_busy),
        .dlcm_state (bus.dlcm_state_i),
        .ack_req    (bus.ack_req_i),
        .fc_req     (bus.fc_req_i),
        .tlp_valid  (bus.tlp_valid_i),
        .tlp_sop    (bus.tlp_sop_i),
        .burst_full (r_dllp_cnt == CNT_MAX),
        .sel        (w_sel)
    );

    assign w_ack_gnt   = w_advance & w_sel[SEL_ACK];
    assign w_fc_gnt    = w_advance & w_sel[SEL_FC];
    // Inside a TLP the stream is offered the slot whenever the PIPE moves,
    // valid or not; at a boundary only a selected sop beat is accepted.
    assign w_tlp_ready = w_advance & (w_busy | w_sel[SEL_TLP]);
    assign w_tlp_take  = w_tlp_ready & bus.tlp_valid_i;

    assign bus.ack_gnt_o   = w_ack_gnt;
    assign bus.fc_gnt_o    = w_fc_gnt;
    assign bus.tlp_ready_o = w_tlp_ready;

    always_comb begin
        w_beat = '0;
        if (w_ack_gnt) begin
            w_beat = dllp_beat(bus.ack_dllp_i);
        end else if (w_fc_gnt) begin
            w_beat = dllp_beat(bus.fc_dllp_i);
        end else if (w_tlp_take) begin
            w_beat = bus.tlp_data_i;
        end
    end

    // ------------------------------------------------------------------
    // FSM and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state    <= TXA_IDLE;
            r_dllp_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_dllp_cnt <= w_dllp_cnt_nxt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_dllp_cnt_nxt = r_dllp_cnt;
        if (r_state == TXA_IDLE) begin
            if (w_advance) begin
                if (!w_active || !w_sop_wait || w_tlp_take) begin
                    // Nobody is being starved, or the waiting TLP just won.
                    w_dllp_cnt_nxt = '0;
                end else if ((w_ack_gnt || w_fc_gnt) && (r_dllp_cnt != CNT_MAX)) begin
                    w_dllp_cnt_nxt = r_dllp_cnt + CNT_W'(1);
                end
                if (w_tlp_take && !bus.tlp_eop_i) begin
                    w_next_state = TXA_TLP_BUSY;
                end
            end
        end else begin
            if (!w_active) begin
                // Link dropped mid-TLP: return to a boundary at once, even
                // under PIPE stall. Replay is handled upstream.
                w_next_state   = TXA_IDLE;
                w_dllp_cnt_nxt = '0;
            end else if (w_tlp_take && bus.tlp_eop_i) begin
                w_next_state = TXA_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: loads only when the PIPE advances, holds otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_dllp  <= 1'b0;
        end else if (bus.pipe_ready_i) begin
            r_data  <= w_beat;
            r_valid <= w_ack_gnt | w_fc_gnt | w_tlp_take;
            r_dllp  <= w_ack_gnt | w_fc_gnt;
        end
    end

    assign bus.dll2pipe_data_o  = r_data;
    assign bus.dll2pipe_valid_o = r_valid;
    assign bus.dll2pipe_dllp_o  = r_dllp;

endmodule
`default_nettype wire

// File: tb/tb_dll_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dll_tx_arbiter
//  Purpose  : Self-checking bench for dll_tx_arbiter: a table of directed
//             vectors with hand-computed grants and registered beats, plus
//             hand-written sequences for starvation, backpressure, abort and
//             asynchronous reset in the middle of traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dll_tx_arbiter;
    import dll_pkg::*;

    localparam logic       H = 1'b1;
    localparam logic       L = 1'b0;
    localparam logic [2:0] S_NONE = 3'd0;
    localparam logic [2:0] S_ACK  = 3'd1;
    localparam logic [2:0] S_FC   = 3'd2;
    localparam logic [2:0] S_TLP  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;
    localparam logic [63:0] ACK_D = 64'hACAC_0001_2345_6789;
    localparam logic [63:0] FC_D  = 64'hFCFC_0002_89AB_CDEF;
    localparam logic [255:0] ACK_BEAT = {192'b0, ACK_D};
    localparam logic [255:0] FC_BEAT  = {192'b0, FC_D};
    localparam int NV = 16;

    typedef struct {
        logic [1:0] dl;
        logic       pr, ak, fc, tv, so, eo;
        logic       ag, fg, tr;
        logic [2:0] src;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[NV];

    dll_tx_arbiter_if bus();

    dll_tx_arbiter #(.MAX_DLLP_BURST(4)) dut (
        .sclk   (clk),
        .srst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input int n);
        return {8{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] dl, input logic pr, input logic ak, input logic fc,
                         input logic tv, input logic so, input logic eo, input logic [255:0] d);
        bus.dlcm_state_i = dl;
        bus.pipe_ready_i = pr;
        bus.ack_req_i    = ak;
        bus.fc_req_i     = fc;
        bus.tlp_valid_i  = tv;
        bus.tlp_sop_i    = so;
        bus.tlp_eop_i    = eo;
        bus.tlp_data_i   = d;
    endtask

    task automatic chk_comb(input string tag, input logic ag, input logic fg, input logic tr);
        chk1({tag, " ack_gnt"},   bus.ack_gnt_o,   ag);
        chk1({tag, " fc_gnt"},    bus.fc_gnt_o,    fg);
        chk1({tag, " tlp_ready"}, bus.tlp_ready_o, tr);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic d, input logic [255:0] data);
        chk1({tag, " valid"}, bus.dll2pipe_valid_o, v);
        chk1({tag, " dllp"},  bus.dll2pipe_dllp_o,  d);
        chkw({tag, " data"},  bus.dll2pipe_data_o,  data);
    endtask

    initial begin
        logic         ev, ed;
        logic [255:0] edata;
        logic         tlp_turn;

        //            dl     pr ak fc tv so eo  ag fg tr  src
        vecs[0]  = '{2'd0,  H, H, H, H, H, H,  L, L, L, S_NONE}; // inactive
        vecs[1]  = '{2'd3,  H, H, H, H, H, H,  L, L, L, S_NONE}; // code 3 = inactive
        vecs[2]  = '{2'd1,  H, H, H, H, H, H,  L, H, L, S_FC};   // init: fc only
        vecs[3]  = '{2'd1,  H, H, L, H, H, H,  L, L, L, S_NONE}; // init: ack/tlp blocked
        vecs[4]  = '{2'd2,  H, H, H, L, L, L,  H, L, L, S_ACK};  // ack beats fc
        vecs[5]  = '{2'd2,  H, L, H, L, L, L,  L, H, L, S_FC};
        vecs[6]  = '{2'd2,  H, L, L, H, H, H,  L, L, H, S_TLP};  // 1-beat TLP
        vecs[7]  = '{2'd2,  H, L, L, H, L, L,  L, L, L, S_NONE}; // no sop at boundary
        vecs[8]  = '{2'd2,  H, L, L, H, H, L,  L, L, H, S_TLP};  // sop -> busy
        vecs[9]  = '{2'd2,  H, H, H, H, L, L,  L, L, H, S_TLP};  // DLLPs held mid-TLP
        vecs[10] = '{2'd2,  L, H, H, H, L, L,  L, L, L, S_HOLD}; // stall
        vecs[11] = '{2'd2,  H, H, H, L, L, L,  L, L, H, S_NONE}; // gap -> idle beat
        vecs[12] = '{2'd2,  H, H, H, H, L, H,  L, L, H, S_TLP};  // eop
        vecs[13] = '{2'd2,  H, H, H, L, L, L,  H, L, L, S_ACK};  // ack right after eop
        vecs[14] = '{2'd2,  H, L, H, L, L, L,  L, H, L, S_FC};
        vecs[15] = '{2'd0,  H, L, L, L, L, L,  L, L, L, S_NONE};

        drive(2'd0, L, L, L, L, L, L, '0);
        bus.ack_dllp_i = ACK_D;
        bus.fc_dllp_i  = FC_D;

        // Reset state
        repeat (2) tick();
        chk_comb("reset", L, L, L);
        chk_out("reset", L, L, '0);
        #2 rst_n = 1'b1;
        tick();

        // Table-driven vectors
        ev = 1'b0; ed = 1'b0; edata = '0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].dl, vecs[i].pr, vecs[i].ak, vecs[i].fc,
                  vecs[i].tv, vecs[i].so, vecs[i].eo, pat(i));
            #1;
            chk_comb($sformatf("v%0d", i), vecs[i].ag, vecs[i].fg, vecs[i].tr);
            case (vecs[i].src)
                S_NONE:  begin ev = L; ed = L; edata = '0;       end
                S_ACK:   begin ev = H; ed = H; edata = ACK_BEAT; end
                S_FC:    begin ev = H; ed = H; edata = FC_BEAT;  end
                S_TLP:   begin ev = H; ed = L; edata = pat(i);   end
                default: ;
            endcase
            tick();
            chk_out($sformatf("v%0d", i), ev, ed, edata);
        end

        // Starvation: 4 ACK beats, then the waiting TLP, then ACK again
        for (int k = 0; k < 6; k++) begin
            drive(2'd2, H, H, H, H, H, H, pat(100 + k));
            #1;
            tlp_turn = (k == 4);
            chk_comb($sformatf("starve%0d", k), !tlp_turn, L, tlp_turn);
            tick();
            chk_out($sformatf("starve%0d", k), H, !tlp_turn, tlp_turn ? pat(100 + k) : ACK_BEAT);
        end
        drive(2'd2, H, L, L, L, L, L, '0);
        tick();

        // Backpressure: 3 stall cycles between beats 1 and 2 of a 4-beat TLP
        drive(2'd2, H, L, L, H, H, L, pat(200));
        #1 chk1("bp b0 tlp_ready", bus.tlp_ready_o, H);
        tick();
        chk_out("bp b0", H, L, pat(200));
        drive(2'd2, H, L, L, H, L, L, pat(201));
        tick();
        chk_out("bp b1", H, L, pat(201));
        for (int s = 0; s < 3; s++) begin
            drive(2'd2, L, H, H, H, L, L, pat(202));
            #1 chk_comb($sformatf("bp stall%0d", s), L, L, L);
            tick();
            chk_out($sformatf("bp stall%0d", s), H, L, pat(201));
        end
        drive(2'd2, H, H, H, H, L, L, pat(202));
        #1 chk_comb("bp b2", L, L, H);
        tick();
        chk_out("bp b2", H, L, pat(202));
        drive(2'd2, H, H, H, H, L, H, pat(203));
        #1 chk_comb("bp b3", L, L, H);
        tick();
        chk_out("bp b3", H, L, pat(203));
        drive(2'd2, H, H, H, L, L, L, '0);
        #1 chk_comb("bp after eop", H, L, L);
        tick();
        chk_out("bp after eop", H, H, ACK_BEAT);
        drive(2'd2, H, L, L, L, L, L, '0);
        tick();

        // Abort: link drops while beat 2 of 4 is presented
        drive(2'd2, H, L, L, H, H, L, pat(300));
        tick();
        drive(2'd2, H, L, L, H, L, L, pat(301));
        tick();
        drive(2'd0, H, L, L, H, L, L, pat(302));
        #1 chk1("abort b2 tlp_ready", bus.tlp_ready_o, H);
        tick();
        chk_out("abort b2", H, L, pat(302));
        drive(2'd0, H, L, L, H, L, H, pat(303));
        #1 chk1("abort next tlp_ready", bus.tlp_ready_o, L);
        tick();
        chk_out("abort +1", L, L, '0);
        tick();
        chk_out("abort +2", L, L, '0);
        drive(2'd2, H, L, L, H, L, L, pat(304));
        #1 chk1("abort idle no-sop tlp_ready", bus.tlp_ready_o, L);
        tick();
        chk_out("abort idle", L, L, '0);

        // Asynchronous reset mid-TLP with every request high
        drive(2'd2, H, L, L, H, H, L, pat(400));
        tick();
        drive(2'd2, H, H, H, H, L, L, pat(401));
        #2 rst_n = 1'b0;
        #1;
        chk_comb("mid-reset", L, L, L);
        chk_out("mid-reset", L, L, '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        drive(2'd2, H, H, H, H, H, H, pat(402));
        #1 chk_comb("post-reset", H, L, L);
        tick();
        chk_out("post-reset", H, H, ACK_BEAT);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
